// File: rtl/panel_scan_ctrl.sv
// Frame scan source and output sink for the pixel pipeline: drives col/row counters over
// one frame and re-frames the pipeline's returning RGB as a 24-bit stream with markers.
module panel_scan_ctrl #(
  parameter int H_ACT    = 1448,
  parameter int V_ACT    = 1072,
  parameter int H_BLANK  = 16,
  parameter int PIPE_LAT = 12,
  parameter int CW       = 12
) (
  input  logic          pixel_clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [7:0]    RM_data,
  input  logic [7:0]    GM_data,
  input  logic [7:0]    BM_data,
  output logic [CW-1:0] Pixel_Col_cnt,
  output logic [CW-1:0] Pixel_Row_cnt,
  output logic          pix_req,
  output logic          busy,
  output logic          out_valid,
  output logic [23:0]   out_data,
  output logic          out_sof,
  output logic          out_eol,
  output logic          out_eof,
  output logic          frame_done
);

  typedef enum logic [2:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_DRAIN, S_DONE} state_t;

  state_t  state_q, state_d;
  logic [CW-1:0] col_q, col_d, row_q, row_d, blank_q, blank_d;
  // tag bits: {pix, sof, eol, eof}; tap k holds the tag driven k cycles ago
  logic [PIPE_LAT:1][3:0] tag_q;
  logic [3:0]  tag_in;
  logic        pipe_empty;
  logic        last_col, last_row;
  logic        out_valid_q, out_sof_q, out_eol_q, out_eof_q;
  logic [23:0] out_data_q;

  assign last_col = (col_q == CW'(H_ACT - 1));
  assign last_row = (row_q == CW'(V_ACT - 1));
  assign pix_req  = (state_q == S_ACTIVE);
  assign tag_in   = {pix_req,
                     pix_req && (col_q == '0) && (row_q == '0),
                     pix_req && last_col,
                     pix_req && last_col && last_row};

  always_comb begin
    pipe_empty = 1'b1;
    for (int k = 1; k <= PIPE_LAT; k++)
      if (tag_q[k][3]) pipe_empty = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    blank_d = blank_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_ACTIVE;
        col_d   = '0;
        row_d   = '0;
      end
      S_ACTIVE: begin
        if (!last_col) begin
          col_d = col_q + 1'b1;
        end else if (last_row) begin
          state_d = S_DRAIN;
          col_d   = '0;
          row_d   = '0;
        end else begin
          col_d   = '0;
          row_d   = row_q + 1'b1;
          blank_d = '0;
          if (H_BLANK > 0) state_d = S_HBLANK;
        end
      end
      S_HBLANK: begin
        if (blank_q == CW'(H_BLANK - 1)) state_d = S_ACTIVE;
        else                             blank_d = blank_q + 1'b1;
      end
      // the eof beat only appears once the whole frame has left the pipeline
      S_DRAIN: if (pipe_empty && out_valid_q && out_eof_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      col_d   = '0;
      row_d   = '0;
      blank_d = '0;
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      blank_q     <= '0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      blank_q <= blank_d;
      if (abort) begin
        tag_q       <= '0;
        out_valid_q <= 1'b0;
        out_sof_q   <= 1'b0;
        out_eol_q   <= 1'b0;
        out_eof_q   <= 1'b0;
      end else begin
        tag_q[1] <= tag_in;
        for (int k = 2; k <= PIPE_LAT; k++) tag_q[k] <= tag_q[k-1];
        out_valid_q <= tag_q[PIPE_LAT][3];
        out_sof_q   <= tag_q[PIPE_LAT][2];
        out_eol_q   <= tag_q[PIPE_LAT][1];
        out_eof_q   <= tag_q[PIPE_LAT][0];
        if (tag_q[PIPE_LAT][3]) out_data_q <= {RM_data, GM_data, BM_data};
      end
    end
  end

  assign Pixel_Col_cnt = col_q;
  assign Pixel_Row_cnt = row_q;
  assign busy          = (state_q != S_IDLE);
  assign frame_done    = (state_q == S_DONE);
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_sof       = out_sof_q;
  assign out_eol       = out_eol_q;
  assign out_eof       = out_eof_q;

endmodule
